// File: rtl/rpl_match_engine.sv
// RPL pattern-matching engine: executes a compiled single-word byte-code program over an input
// buffer, one instruction per cycle, backtracking through a bounded stack of {pc, pos} entries.
module rpl_match_engine #(
    parameter int PC_W     = 10,
    parameter int POS_W    = 16,
    parameter int BT_DEPTH = 16,
    parameter int CYC_W    = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [PC_W-1:0]               start_pc_i,
    input  logic [POS_W-1:0]              start_pos_i,
    input  logic [POS_W-1:0]              in_len_i,
    input  logic [CYC_W-1:0]              cyc_limit_i,
    input  logic                          abort_i,
    output logic [PC_W-1:0]               code_addr_o,
    input  logic [31:0]                   code_data_i,
    output logic [POS_W-1:0]              in_addr_o,
    input  logic [7:0]                    in_data_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          matched_o,
    output logic [POS_W-1:0]              end_pos_o,
    output logic [1:0]                    err_code_o,
    output logic [$clog2(BT_DEPTH+1)-1:0] bt_max_o,
    output logic [CYC_W-1:0]              cyc_cnt_o
);
    localparam int SP_W  = $clog2(BT_DEPTH + 1);
    localparam int IDX_W = (BT_DEPTH > 1) ? $clog2(BT_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_OVF   = 2'd1;
    localparam logic [1:0] ERR_BAD   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    localparam logic [7:0] OP_CHAR    = 8'd0,  OP_ANY     = 8'd1,  OP_RANGE   = 8'd2;
    localparam logic [7:0] OP_SPAN    = 8'd3,  OP_TEST    = 8'd4,  OP_CHOICE  = 8'd5;
    localparam logic [7:0] OP_COMMIT  = 8'd6,  OP_PCOMMIT = 8'd7,  OP_BCOMMIT = 8'd8;
    localparam logic [7:0] OP_JMP     = 8'd9,  OP_FAIL    = 8'd10, OP_FAIL2   = 8'd11;
    localparam logic [7:0] OP_BEHIND  = 8'd12, OP_END     = 8'd13, OP_HALT    = 8'd14;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  start_pos_q, start_pos_d;
    logic [POS_W-1:0]  in_len_q, in_len_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              matched_q, matched_d;
    logic [POS_W-1:0]  end_pos_q, end_pos_d;
    logic [1:0]        err_q, err_d;
    logic [SP_W-1:0]   bt_max_q, bt_max_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;

    logic [PC_W-1:0]   stk_pc_q  [BT_DEPTH];
    logic [POS_W-1:0]  stk_pos_q [BT_DEPTH];
    logic              stk_we;
    logic [IDX_W-1:0]  stk_widx;
    logic [PC_W-1:0]   stk_wpc;
    logic [POS_W-1:0]  stk_wpos;

    logic [7:0]        op, arg_a, arg_b;
    logic [15:0]       off;
    logic              eof, stk_empty, stk_full, in_range;
    logic [PC_W-1:0]   pc_inc, pc_rel;
    logic [IDX_W-1:0]  top_idx, sec_idx;
    logic [SP_W-1:0]   sp_inc;
    logic              fail, fail_twice, finish, fin_match;
    logic [1:0]        fin_err;

    assign op        = code_data_i[31:24];
    assign arg_a     = code_data_i[23:16];
    assign arg_b     = code_data_i[15:8];
    assign off       = code_data_i[15:0];
    // EOF gates every use of in_data_i, so reads past in_len are harmless.
    assign eof       = (pos_q >= in_len_q);
    assign in_range  = (in_data_i >= arg_a) && (in_data_i <= arg_b);
    assign pc_inc    = pc_q + PC_W'(1);
    assign pc_rel    = pc_q + PC_W'($signed(off));
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_W'(BT_DEPTH));
    assign sp_inc    = sp_q + SP_W'(1);
    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign sec_idx   = IDX_W'(sp_q - SP_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            pos_q       <= '0;
            start_pos_q <= '0;
            in_len_q    <= '0;
            sp_q        <= '0;
            matched_q   <= 1'b0;
            end_pos_q   <= '0;
            err_q       <= ERR_OK;
            bt_max_q    <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            pos_q       <= pos_d;
            start_pos_q <= start_pos_d;
            in_len_q    <= in_len_d;
            sp_q        <= sp_d;
            matched_q   <= matched_d;
            end_pos_q   <= end_pos_d;
            err_q       <= err_d;
            bt_max_q    <= bt_max_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    // NOTE: stack storage is not reset; sp_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (stk_we) begin
            stk_pc_q[stk_widx]  <= stk_wpc;
            stk_pos_q[stk_widx] <= stk_wpos;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        pos_d       = pos_q;
        start_pos_d = start_pos_q;
        in_len_d    = in_len_q;
        sp_d        = sp_q;
        matched_d   = matched_q;
        end_pos_d   = end_pos_q;
        err_d       = err_q;
        bt_max_d    = bt_max_q;
        cyc_cnt_d   = cyc_cnt_q;
        stk_we      = 1'b0;
        stk_widx    = top_idx;
        stk_wpc     = pc_rel;
        stk_wpos    = pos_q;
        fail        = 1'b0;
        fail_twice  = 1'b0;
        finish      = 1'b0;
        fin_match   = 1'b0;
        fin_err     = ERR_OK;

        if (abort_i) begin
            state_d   = S_DONE;
            matched_d = 1'b0;
            end_pos_d = start_pos_q;
            err_d     = ERR_ABORT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d     = S_RUN;
                        pc_d        = start_pc_i;
                        pos_d       = start_pos_i;
                        start_pos_d = start_pos_i;
                        in_len_d    = in_len_i;
                        sp_d        = '0;
                        matched_d   = 1'b0;
                        end_pos_d   = start_pos_i;
                        err_d       = ERR_OK;
                        bt_max_d    = '0;
                        cyc_cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    if (cyc_limit_i != '0 && cyc_cnt_q == cyc_limit_i) begin
                        finish  = 1'b1;
                        fin_err = ERR_ABORT;
                    end else begin
                        if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                        case (op)
                            OP_CHAR:   if (!eof && in_data_i == arg_a) begin pos_d = pos_q + POS_W'(1); pc_d = pc_inc; end
                                       else fail = 1'b1;
                            OP_ANY:    if (!eof) begin pos_d = pos_q + POS_W'(1); pc_d = pc_inc; end
                                       else fail = 1'b1;
                            OP_RANGE:  if (!eof && in_range) begin pos_d = pos_q + POS_W'(1); pc_d = pc_inc; end
                                       else fail = 1'b1;
                            OP_SPAN:   if (!eof && in_range) pos_d = pos_q + POS_W'(1);
                                       else pc_d = pc_inc;
                            OP_TEST:   pc_d = (!eof && in_data_i == arg_a) ? pc_inc : pc_rel;
                            OP_CHOICE: begin
                                if (stk_full) begin
                                    finish  = 1'b1;
                                    fin_err = ERR_OVF;
                                end else begin
                                    stk_we   = 1'b1;
                                    stk_widx = IDX_W'(sp_q);
                                    sp_d     = sp_inc;
                                    pc_d     = pc_inc;
                                    if (sp_inc > bt_max_q) bt_max_d = sp_inc;
                                end
                            end
                            OP_COMMIT, OP_PCOMMIT, OP_BCOMMIT: begin
                                if (stk_empty) begin
                                    finish  = 1'b1;
                                    fin_err = ERR_BAD;
                                end else begin
                                    pc_d = pc_rel;
                                    if (op == OP_PCOMMIT) begin
                                        stk_we  = 1'b1;
                                        stk_wpc = stk_pc_q[top_idx];
                                    end else begin
                                        sp_d = sp_q - SP_W'(1);
                                        if (op == OP_BCOMMIT) pos_d = stk_pos_q[top_idx];
                                    end
                                end
                            end
                            OP_JMP:    pc_d = pc_rel;
                            OP_FAIL:   fail = 1'b1;
                            OP_FAIL2: begin
                                if (stk_empty) begin
                                    finish  = 1'b1;
                                    fin_err = ERR_BAD;
                                end else begin
                                    fail       = 1'b1;
                                    fail_twice = 1'b1;
                                end
                            end
                            OP_BEHIND: if (pos_q < POS_W'(arg_a)) fail = 1'b1;
                                       else begin pos_d = pos_q - POS_W'(arg_a); pc_d = pc_inc; end
                            OP_END: begin
                                finish    = 1'b1;
                                fin_match = 1'b1;
                            end
                            OP_HALT:   finish = 1'b1;
                            default: begin
                                finish  = 1'b1;
                                fin_err = ERR_BAD;
                            end
                        endcase

                        // Backtrack resolves in the failing cycle; FAIL_TWICE discards the top entry first.
                        if (fail) begin
                            if (fail_twice ? (sp_q == SP_W'(1)) : stk_empty) begin
                                finish = 1'b1;
                            end else if (fail_twice) begin
                                pc_d  = stk_pc_q[sec_idx];
                                pos_d = stk_pos_q[sec_idx];
                                sp_d  = sp_q - SP_W'(2);
                            end else begin
                                pc_d  = stk_pc_q[top_idx];
                                pos_d = stk_pos_q[top_idx];
                                sp_d  = sp_q - SP_W'(1);
                            end
                        end
                    end

                    if (finish) begin
                        state_d   = S_DONE;
                        matched_d = fin_match;
                        end_pos_d = fin_match ? pos_q : start_pos_q;
                        err_d     = fin_err;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == S_RUN);
        done_o = (state_q == S_DONE);
    end

    assign code_addr_o = pc_q;
    assign in_addr_o   = pos_q;
    assign matched_o   = matched_q;
    assign end_pos_o   = end_pos_q;
    assign err_code_o  = err_q;
    assign bt_max_o    = bt_max_q;
    assign cyc_cnt_o   = cyc_cnt_q;

endmodule

// File: tb/tb_rpl_match_engine.sv
// Directed bench for rpl_match_engine: table of small programs with hand-computed results,
// plus abort and mid-run reset sequences. Code and input RAMs are modelled as comb-read arrays.
module tb_rpl_match_engine;
    localparam int PC_W     = 10;
    localparam int POS_W    = 16;
    localparam int BT_DEPTH = 4;
    localparam int CYC_W    = 24;
    localparam int BT_W     = $clog2(BT_DEPTH + 1);

    localparam logic [7:0] OP_CHAR = 8'd0, OP_ANY = 8'd1, OP_RANGE = 8'd2, OP_SPAN = 8'd3;
    localparam logic [7:0] OP_TEST = 8'd4, OP_CHOICE = 8'd5, OP_COMMIT = 8'd6, OP_PCOMMIT = 8'd7;
    localparam logic [7:0] OP_BCOMMIT = 8'd8, OP_JMP = 8'd9, OP_FAIL2 = 8'd11;
    localparam logic [7:0] OP_BEHIND = 8'd12, OP_END = 8'd13, OP_HALT = 8'd14;
    localparam logic [31:0] HALT_W = {OP_HALT, 24'h0};

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, abort_i;
    logic [PC_W-1:0]   start_pc_i;
    logic [POS_W-1:0]  start_pos_i, in_len_i;
    logic [CYC_W-1:0]  cyc_limit_i;
    logic [PC_W-1:0]   code_addr_o;
    logic [31:0]       code_data_i;
    logic [POS_W-1:0]  in_addr_o;
    logic [7:0]        in_data_i;
    logic              busy_o, done_o, matched_o;
    logic [POS_W-1:0]  end_pos_o;
    logic [1:0]        err_code_o;
    logic [BT_W-1:0]   bt_max_o;
    logic [CYC_W-1:0]  cyc_cnt_o;

    logic [31:0] code_mem [1024];
    logic [7:0]  in_mem   [65536];

    assign code_data_i = code_mem[code_addr_o];
    assign in_data_i   = in_mem[in_addr_o];

    always #5 clk = ~clk;

    rpl_match_engine #(.PC_W(PC_W), .POS_W(POS_W), .BT_DEPTH(BT_DEPTH), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .start_pc_i(start_pc_i),
        .start_pos_i(start_pos_i), .in_len_i(in_len_i), .cyc_limit_i(cyc_limit_i),
        .abort_i(abort_i), .code_addr_o(code_addr_o), .code_data_i(code_data_i),
        .in_addr_o(in_addr_o), .in_data_i(in_data_i), .busy_o(busy_o), .done_o(done_o),
        .matched_o(matched_o), .end_pos_o(end_pos_o), .err_code_o(err_code_o),
        .bt_max_o(bt_max_o), .cyc_cnt_o(cyc_cnt_o)
    );

    typedef struct {
        string name;
        int    base;
        int    len;
        string inp;
        int    spos;
        int    lim;
        int    ematch;
        int    eend;
        int    eerr;
        int    ebt;
        int    ecyc;
    } vec_t;

    vec_t        vecs [32];
    int          nv = 0;
    logic [31:0] rom [256];
    int          rom_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [31:0] w(input logic [7:0] op, input logic [7:0] a, input logic [15:0] o);
        return {op, a, o};
    endfunction

    function automatic logic [31:0] r(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b, 8'h00};
    endfunction

    task automatic emit(input logic [31:0] word);
        rom[rom_n] = word;
        rom_n++;
    endtask

    task automatic add_vec(input string nm, input int base, input string inp, input int spos,
                           input int lim, input int em, input int ee, input int er,
                           input int eb, input int ec);
        vecs[nv].name = nm;   vecs[nv].base = base; vecs[nv].len = rom_n - base;
        vecs[nv].inp  = inp;  vecs[nv].spos = spos; vecs[nv].lim = lim;
        vecs[nv].ematch = em; vecs[nv].eend = ee;   vecs[nv].eerr = er;
        vecs[nv].ebt  = eb;   vecs[nv].ecyc = ec;
        nv++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic load_input(input string inp);
        for (int i = 0; i < 64; i++) in_mem[i] = 8'h00;
        for (int i = 0; i < inp.len(); i++) in_mem[i] = inp[i];
    endtask

    task automatic start_run(input int spos, input int len, input int lim);
        start_pc_i  = '0;
        start_pos_i = POS_W'(spos);
        in_len_i    = POS_W'(len);
        cyc_limit_i = CYC_W'(lim);
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        for (int i = 0; i < 1024; i++) code_mem[i] = HALT_W;
        for (int i = 0; i < v.len; i++) code_mem[i] = rom[v.base + i];
        load_input(v.inp);
        start_run(v.spos, v.inp.len(), v.lim);
        wait_done(seen);
        check({v.name, ".done_seen"}, 32'(seen), 32'd1);
        check({v.name, ".matched"}, 32'(matched_o), v.ematch);
        check({v.name, ".end_pos"}, 32'(end_pos_o), v.eend);
        check({v.name, ".err_code"}, 32'(err_code_o), v.eerr);
        check({v.name, ".bt_max"}, 32'(bt_max_o), v.ebt);
        check({v.name, ".cyc_cnt"}, 32'(cyc_cnt_o), v.ecyc);
        @(negedge clk);
        check({v.name, ".done_pulse"}, {30'd0, done_o, busy_o}, 32'd0);
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, ".busy"}, 32'(busy_o), 32'd0);
        check({nm, ".done"}, 32'(done_o), 32'd0);
        check({nm, ".matched"}, 32'(matched_o), 32'd0);
        check({nm, ".err_code"}, 32'(err_code_o), 32'd0);
        check({nm, ".bt_max"}, 32'(bt_max_o), 32'd0);
        check({nm, ".cyc_cnt"}, 32'(cyc_cnt_o), 32'd0);
        check({nm, ".end_pos"}, 32'(end_pos_o), 32'd0);
        check({nm, ".pc_pos"}, {6'd0, code_addr_o, in_addr_o}, 32'd0);
    endtask

    initial begin
        int b;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        start_pc_i = '0; start_pos_i = '0; in_len_i = '0; cyc_limit_i = '0;
        for (int i = 0; i < 1024; i++) code_mem[i] = HALT_W;
        for (int i = 0; i < 65536; i++) in_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        b = rom_n; emit(w(OP_CHAR, "a", 0)); emit(w(OP_CHAR, "b", 0)); emit(w(OP_END, 0, 0));
        add_vec("seq_ab", b, "abc", 0, 0, 1, 2, 0, 0, 3);
        b = rom_n; emit(w(OP_CHOICE, 0, 3)); emit(w(OP_CHAR, "x", 0)); emit(w(OP_COMMIT, 0, 2));
        emit(w(OP_CHAR, "y", 0)); emit(w(OP_END, 0, 0));
        add_vec("choice_alt", b, "y", 0, 0, 1, 1, 0, 1, 4);
        b = rom_n; emit(r(OP_SPAN, "0", "9")); emit(w(OP_END, 0, 0));
        add_vec("span_digits", b, "1234z", 0, 0, 1, 4, 0, 0, 6);
        add_vec("span_empty", b, "", 0, 0, 1, 0, 0, 0, 2);
        b = rom_n; repeat (5) emit(w(OP_CHOICE, 0, 1)); emit(w(OP_END, 0, 0));
        add_vec("bt_overflow", b, "abcdef", 3, 0, 0, 3, 1, 4, 5);
        b = rom_n; emit(w(OP_CHAR, "q", 0)); emit(w(OP_END, 0, 0));
        add_vec("char_nomatch", b, "a", 0, 0, 0, 0, 0, 0, 1);
        b = rom_n; emit(w(OP_COMMIT, 0, 1));
        add_vec("commit_empty", b, "ab", 1, 0, 0, 1, 2, 0, 1);
        b = rom_n; emit(w(OP_JMP, 0, 0));
        add_vec("cyc_limit", b, "", 0, 100, 0, 0, 3, 0, 100);
        b = rom_n; emit(w(OP_TEST, "a", 3)); emit(w(OP_ANY, 0, 0)); emit(w(OP_END, 0, 0));
        emit(w(OP_END, 0, 0));
        add_vec("test_hit", b, "ab", 0, 0, 1, 1, 0, 0, 3);
        add_vec("test_miss", b, "bb", 0, 0, 1, 0, 0, 0, 2);
        b = rom_n; emit(r(OP_RANGE, "a", "f")); emit(r(OP_RANGE, "a", "f"));
        emit(w(OP_BEHIND, 1, 0)); emit(w(OP_CHAR, "c", 0)); emit(w(OP_END, 0, 0));
        add_vec("range_behind", b, "acx", 0, 0, 1, 2, 0, 0, 5);
        b = rom_n; emit(w(OP_BEHIND, 2, 0)); emit(w(OP_END, 0, 0));
        add_vec("behind_fail", b, "ab", 1, 0, 0, 1, 0, 0, 1);
        b = rom_n; emit(w(OP_CHOICE, 0, 4)); emit(w(OP_CHOICE, 0, 2)); emit(w(OP_FAIL2, 0, 0));
        emit(HALT_W); emit(w(OP_END, 0, 0));
        add_vec("fail_twice2", b, "zz", 0, 0, 1, 0, 0, 2, 4);
        b = rom_n; emit(w(OP_CHOICE, 0, 2)); emit(w(OP_FAIL2, 0, 0)); emit(w(OP_END, 0, 0));
        add_vec("fail_twice1", b, "zz", 0, 0, 0, 0, 0, 1, 2);
        b = rom_n; emit(w(OP_FAIL2, 0, 0));
        add_vec("fail_twice0", b, "zz", 0, 0, 0, 0, 2, 0, 1);
        b = rom_n; emit(w(OP_CHOICE, 0, 3)); emit(w(OP_CHAR, "a", 0)); emit(w(OP_PCOMMIT, 0, 16'hFFFF));
        emit(w(OP_END, 0, 0));
        add_vec("pcommit_loop", b, "aab", 0, 0, 1, 2, 0, 1, 7);
        b = rom_n; emit(w(OP_CHOICE, 0, 3)); emit(w(OP_ANY, 0, 0)); emit(w(OP_BCOMMIT, 0, 2));
        emit(HALT_W); emit(w(OP_END, 0, 0));
        add_vec("back_commit", b, "x", 0, 0, 1, 0, 0, 1, 4);
        b = rom_n; emit({8'h0F, 24'h0});
        add_vec("bad_opcode", b, "x", 0, 0, 0, 0, 2, 0, 1);

        for (int i = 0; i < nv; i++) run_vec(vecs[i]);

        // Abort mid-run; a start pulse while busy must not disturb the latched start position.
        for (int i = 0; i < 1024; i++) code_mem[i] = HALT_W;
        code_mem[0] = w(OP_JMP, 0, 0);
        load_input("abcdefgh");
        start_run(5, 8, 0);
        repeat (10) @(negedge clk);
        check("abort.busy", 32'(busy_o), 32'd1);
        start_pos_i = 16'd9;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort.done", 32'(done_o), 32'd1);
        check("abort.err_code", 32'(err_code_o), 32'd3);
        check("abort.matched", 32'(matched_o), 32'd0);
        check("abort.end_pos", 32'(end_pos_o), 32'd5);
        check("abort.cyc_cnt", 32'(cyc_cnt_o), 32'd11);
        @(negedge clk);
        check("abort.idle", {30'd0, done_o, busy_o}, 32'd0);

        // Asynchronous reset in the middle of a run.
        start_run(7, 8, 0);
        repeat (20) @(negedge clk);
        check("rst_mid.busy", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.stays_idle", {30'd0, done_o, busy_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
